// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 scan timing and the shared coordinate type for the
// pixel-scan interface.
package vga_timing_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_RANGE = 1 << COORD_W;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus sync/active decodes of the
// value the counter will hold after this cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   active
);

    localparam int     TOTAL   = VISIBLE + FP + SYNC + BP;
    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_LO = coord_t'(VISIBLE + FP);
    localparam coord_t SYNC_HI = coord_t'(VISIBLE + FP + SYNC);
    localparam coord_t VIS_END = coord_t'(VISIBLE);

    coord_t count_next;

    assign wrap = en && (count == LAST);

    always_comb begin
        count_next = count;
        if (en) count_next = (count == LAST) ? '0 : count + 1'b1;
    end

    // Decodes look ahead so the registered sync/blank line up with the count.
    assign sync_n = !in_window(count_next, SYNC_LO, SYNC_HI);
    assign active = count_next < VIS_END;

    always_ff @(posedge Clk) begin
        if (Reset) count <= '0;
        else       count <= count_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan timing source: pixel clock divider, h/v scan counters, registered
// sync/blank outputs and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        vga_clk,
    output logic        pixel_en,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if (CLK_DIV < 2) begin : g_bad_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be at least 2");
    end
    if ((H_VISIBLE + H_FP + H_SYNC + H_BP > COORD_RANGE) ||
        (V_VISIBLE + V_FP + V_SYNC + V_BP > COORD_RANGE)) begin : g_bad_total
        $fatal(1, "vga_timing_gen: line or frame total exceeds 10-bit counters");
    end

    logic [DIV_W-1:0] div, div_next;
    logic h_wrap, v_wrap, h_sync_n, v_sync_n, h_active, v_active;

    assign pixel_en = (div == DIV_LAST);
    assign div_next = pixel_en ? '0 : div + 1'b1;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .Clk(Clk), .Reset(Reset), .en(pixel_en),
        .count(DrawX), .wrap(h_wrap), .sync_n(h_sync_n), .active(h_active)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .Clk(Clk), .Reset(Reset), .en(h_wrap),
        .count(DrawY), .wrap(v_wrap), .sync_n(v_sync_n), .active(v_active)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div         <= '0;
            vga_clk     <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            div         <= div_next;
            vga_clk     <= (div_next >= DIV_HALF);
            frame_start <= v_wrap;
            if (v_wrap) frame_count <= frame_count + 1'b1;
            if (pixel_en) begin
                hs    <= h_sync_n;
                vs    <= v_sync_n;
                blank <= h_active && v_active;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, a shrunken frame for multi-frame
// behaviour, and a CLK_DIV=4 divider variant.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pe;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int d;
        int hv, hf, hsw, hb;
        int vv, vf, vsw, vb;
    } tcfg_t;

    typedef struct {
        int k;
        int x;
        int y;
        bit hs;
        bit blank;
    } vec_t;

    logic Clk = 1'b0;
    logic reset0 = 1'b1, reset1 = 1'b1, reset2 = 1'b1;

    logic        vclk0, pe0, hs0, vs0, blank0, fs0;
    logic        vclk1, pe1, hs1, vs1, blank1, fs1;
    logic        vclk2, pe2, hs2, vs2, blank2, fs2;
    logic [9:0]  x0, y0, x1, y1, x2, y2;
    logic [15:0] fc0, fc1, fc2;

    always #5 Clk = ~Clk;

    vga_timing_gen u0 (
        .Clk(Clk), .Reset(reset0), .vga_clk(vclk0), .pixel_en(pe0), .hs(hs0), .vs(vs0),
        .blank(blank0), .DrawX(x0), .DrawY(y0), .frame_start(fs0), .frame_count(fc0)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u1 (
        .Clk(Clk), .Reset(reset1), .vga_clk(vclk1), .pixel_en(pe1), .hs(hs1), .vs(vs1),
        .blank(blank1), .DrawX(x1), .DrawY(y1), .frame_start(fs1), .frame_count(fc1)
    );

    vga_timing_gen #(.CLK_DIV(4)) u2 (
        .Clk(Clk), .Reset(reset2), .vga_clk(vclk2), .pixel_en(pe2), .hs(hs2), .vs(vs2),
        .blank(blank2), .DrawX(x2), .DrawY(y2), .frame_start(fs2), .frame_count(fc2)
    );

    int   vectors = 0;
    int   miscompares = 0;
    obs_t sbq[$];
    obs_t rst_obs;
    int   n_pe, n_hs_low, n_vs_low, n_fs, n_vclk;

    function automatic obs_t sample(int sel);
        case (sel)
            0:       return {pe0, vclk0, hs0, vs0, blank0, fs0, x0, y0, fc0};
            1:       return {pe1, vclk1, hs1, vs1, blank1, fs1, x1, y1, fc1};
            default: return {pe2, vclk2, hs2, vs2, blank2, fs2, x2, y2, fc2};
        endcase
    endfunction

    // Closed-form expectation after k clock edges since the reset edge.
    function automatic obs_t model(int k, tcfg_t c);
        obs_t m;
        int ht = c.hv + c.hf + c.hsw + c.hb;
        int vt = c.vv + c.vf + c.vsw + c.vb;
        int p  = k / c.d;
        int ph = k % c.d;
        int x  = p % ht;
        int y  = (p / ht) % vt;
        m.pe    = (ph == c.d - 1);
        m.vclk  = (ph >= c.d / 2);
        m.hs    = !(x >= c.hv + c.hf && x < c.hv + c.hf + c.hsw);
        m.vs    = !(y >= c.vv + c.vf && y < c.vv + c.vf + c.vsw);
        m.blank = (p > 0) && (x < c.hv) && (y < c.vv);
        m.fs    = (p > 0) && (p % (ht * vt) == 0) && (ph == 0);
        m.x     = 10'(x);
        m.y     = 10'(y);
        m.fc    = 16'(p / (ht * vt));
        return m;
    endfunction

    task automatic check_obs(string name, int k, obs_t a, obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s k=%0d got x=%0d y=%0d pe=%b vclk=%b hs=%b vs=%b blank=%b fs=%b fc=%0d want x=%0d y=%0d pe=%b vclk=%b hs=%b vs=%b blank=%b fs=%b fc=%0d",
                     name, k, a.x, a.y, a.pe, a.vclk, a.hs, a.vs, a.blank, a.fs, a.fc,
                     e.x, e.y, e.pe, e.vclk, e.hs, e.vs, e.blank, e.fs, e.fc);
        end
    endtask

    task automatic check_int(string name, int a, int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, a, e);
        end
    endtask

    task automatic clear_stats();
        n_pe = 0; n_hs_low = 0; n_vs_low = 0; n_fs = 0; n_vclk = 0;
    endtask

    // Expected record queued at the driving edge, popped when sampled.
    task automatic run(int sel, tcfg_t c, int k_from, int k_to);
        obs_t e, a;
        for (int k = k_from; k <= k_to; k++) begin
            @(posedge Clk);
            sbq.push_back(model(k, c));
            @(negedge Clk);
            e = sbq.pop_front();
            a = sample(sel);
            check_obs("scan", k, a, e);
            if (a.pe) n_pe++;
            if (a.pe && !a.hs) n_hs_low++;
            if (a.pe && !a.vs) n_vs_low++;
            if (a.fs) n_fs++;
            if (a.vclk) n_vclk++;
        end
    endtask

    tcfg_t c0, c1, c2;
    vec_t  vt[11];

    initial begin
        c0 = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        c1 = '{2, 8, 2, 3, 2, 6, 2, 2, 3};
        c2 = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        rst_obs = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 16'd0};

        vt[0]  = '{0,    0,   0, 1'b1, 1'b0};
        vt[1]  = '{2,    1,   0, 1'b1, 1'b1};
        vt[2]  = '{1279, 639, 0, 1'b1, 1'b1};
        vt[3]  = '{1280, 640, 0, 1'b1, 1'b0};
        vt[4]  = '{1311, 655, 0, 1'b1, 1'b0};
        vt[5]  = '{1312, 656, 0, 1'b0, 1'b0};
        vt[6]  = '{1503, 751, 0, 1'b0, 1'b0};
        vt[7]  = '{1504, 752, 0, 1'b1, 1'b0};
        vt[8]  = '{1599, 799, 0, 1'b1, 1'b0};
        vt[9]  = '{1600, 0,   1, 1'b1, 1'b1};
        vt[10] = '{1602, 1,   1, 1'b1, 1'b1};

        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check_obs("reset_u0", 0, sample(0), rst_obs);
        check_obs("reset_u1", 0, sample(1), rst_obs);
        check_obs("reset_u2", 0, sample(2), rst_obs);

        // Default timing: one full line plus a pixel, with table checkpoints.
        reset0 = 1'b0;
        clear_stats();
        for (int i = 0; i < 11; i++) begin
            obs_t a;
            run(0, c0, (i == 0) ? 1 : vt[i-1].k + 1, vt[i].k);
            a = sample(0);
            check_int($sformatf("tbl%0d_x", i), int'(a.x), vt[i].x);
            check_int($sformatf("tbl%0d_y", i), int'(a.y), vt[i].y);
            check_int($sformatf("tbl%0d_hs", i), int'(a.hs), int'(vt[i].hs));
            check_int($sformatf("tbl%0d_blank", i), int'(a.blank), int'(vt[i].blank));
        end
        check_int("line_hs_low_strobes", n_hs_low, 96);
        check_int("line_pixel_en_count", n_pe, 801);
        reset0 = 1'b1;

        // Shrunken frame (15 x 13 pixels): vsync width, frame pulses, counter.
        @(negedge Clk);
        reset1 = 1'b0;
        clear_stats();
        run(1, c1, 1, 390);
        check_int("frame1_vs_low_strobes", n_vs_low, 2 * 15);
        check_int("frame1_fs_pulses", n_fs, 1);
        run(1, c1, 391, 785);
        check_int("frame2_fs_pulses", n_fs, 2);
        check_int("frame2_count", int'(fc1), 2);
        run(1, c1, 786, 850);
        check_int("mid_x", int'(x1), 5);
        check_int("mid_y", int'(y1), 2);

        // One-cycle reset mid-frame restarts the scan without a frame pulse.
        reset1 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        reset1 = 1'b0;
        check_obs("midreset_u1", 0, sample(1), rst_obs);
        clear_stats();
        run(1, c1, 1, 400);
        check_int("post_reset_fs_pulses", n_fs, 1);
        reset1 = 1'b1;

        // CLK_DIV=4: strobe every 4 clocks, 2-high/2-low pixel clock.
        @(negedge Clk);
        reset2 = 1'b0;
        clear_stats();
        run(2, c2, 1, 3200);
        check_int("div4_pixel_en_count", n_pe, 800);
        check_int("div4_vclk_high", n_vclk, 1600);
        check_int("div4_line_x", int'(x2), 0);
        check_int("div4_line_y", int'(y2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
